// File: rtl/if_id_reg_pkg.sv
// ----------------------------------------------------------------------------
// if_id_reg_pkg
// Shared constants for the IF/ID pipeline register of the RV32I core.
//   - INSTR_NOP        : canonical bubble encoding (addi x0,x0,0)
//   - SKID_EMPTY/FULL  : encodings of the one-entry skid buffer state
//   - OPC_*            : base RV32I major opcodes used by the decode stage
// No ports; imported by if_id_skid_buf and if_id_reg.
// ----------------------------------------------------------------------------
package if_id_reg_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [0:0] SKID_EMPTY = 1'b0;
    localparam logic [0:0] SKID_FULL  = 1'b1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // PC and instruction travelling together through the skid entry.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_pkt_t;

    // Present a bubble whenever the slot does not hold a real instruction.
    function automatic logic [31:0] bubble_or_instr(input logic vld, input logic [31:0] instr);
        return vld ? instr : INSTR_NOP;
    endfunction

endpackage

// File: rtl/if_id_reg_skid_buf.sv
// ----------------------------------------------------------------------------
// if_id_skid_buf
// Single-entry holding register (PC + instruction) with a full flag. Catches
// the one instruction fetch delivers in the cycle a stall begins, since
// fetch_ready only drops one cycle later.
//
// Ports:
//   clk       in   core clock
//   rst       in   async active-high reset, empties the entry
//   push      in   capture pc_in/instr_in, entry becomes full
//   pop       in   entry consumed by ID, becomes empty
//   clear     in   discard entry (flush); wins over push and pop
//   pc_in     in   PC to capture
//   instr_in  in   instruction to capture
//   full      out  entry holds an instruction
//   pc        out  held PC
//   instr     out  held instruction
// ----------------------------------------------------------------------------
module if_id_skid_buf
    import if_id_reg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    logic [0:0] state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SKID_EMPTY;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            state <= SKID_EMPTY;
        end else if (push) begin
            state <= SKID_FULL;
            pc    <= pc_in;
            instr <= instr_in;
        end else if (pop) begin
            state <= SKID_EMPTY;
        end
    end

    assign full = (state == SKID_FULL);

endmodule

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register of the 5-stage RV32I core. Holds PC and instruction
// for decode, honours hazard-unit stall and branch flush, and uses a one-entry
// skid buffer so the instruction fetched while a stall begins is not lost.
// Bubbles always present NOP_INSTR.
//
// Optional feature (macro IF_ID_PERF_EN): adds saturating 32-bit counters
// stall_cnt_o (cycles with stall_i && !flush_i) and flush_cnt_o (cycles with
// flush_i). Without the macro those ports do not exist.
//
// Ports:
//   clk_i          in   core clock, rising edge
//   rst_i          in   async active-high reset
//   stall_i        in   hold ID contents this cycle
//   flush_i        in   discard ID and skid contents (beats stall_i)
//   valid_i        in   fetch presents a valid instruction
//   pc_i           in   PC of fetched instruction
//   instr_i        in   fetched instruction word
//   fetch_ready_o  out  fetch may present a new instruction (skid empty)
//   valid_o        out  ID holds a real instruction
//   pc_o           out  PC of ID instruction
//   instr_o        out  ID instruction, NOP_INSTR when valid_o=0
//   stall_cnt_o    out  [IF_ID_PERF_EN] stall cycle counter
//   flush_cnt_o    out  [IF_ID_PERF_EN] flush cycle counter
// ----------------------------------------------------------------------------
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            fetch_ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    logic            skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic            accept;
    logic            skid_push;
    logic            skid_pop;
    logic            skid_clear;

    // Ready comes straight from the skid flop, so there is no path from
    // stall_i to fetch_ready_o.
    assign fetch_ready_o = ~skid_full;
    assign accept        = valid_i & ~skid_full;

    assign skid_clear = flush_i;
    assign skid_push  = ~flush_i &  stall_i & accept;
    assign skid_pop   = ~flush_i & ~stall_i & skid_full;

    if_id_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (skid_push),
        .pop      (skid_pop),
        .clear    (skid_clear),
        .pc_in    (pc_i),
        .instr_in (instr_i),
        .full     (skid_full),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            pc_o    <= '0;
            instr_o <= NOP_INSTR[XLEN-1:0];
        end else if (flush_i) begin
            // PC is left as-is; only the instruction becomes a bubble.
            valid_o <= 1'b0;
            instr_o <= NOP_INSTR[XLEN-1:0];
        end else if (!stall_i) begin
            if (skid_full) begin
                // Skid entry is older than anything fetch offers now, and
                // fetch was back-pressured this cycle anyway.
                valid_o <= 1'b1;
                pc_o    <= skid_pc;
                instr_o <= skid_instr;
            end else begin
                valid_o <= valid_i;
                pc_o    <= pc_i;
                instr_o <= valid_i ? instr_i : NOP_INSTR[XLEN-1:0];
            end
        end
    end

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            // A stall overlapped by a flush counts as a flush only.
            if (flush_i) begin
                if (flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
            end else if (stall_i) begin
                if (stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage RV32I core, between fetch (PC, instruction memory) and decode (register file, Sign_Extend, control).
- Holds PC and instruction for the ID stage.
- Supports hazard-unit stall and branch flush.
- Adds a one-entry skid buffer so that an instruction fetched during a stall is not lost.
- Bubbles present the canonical NOP, so downstream immediate generation sees zero.

Parameters:
- XLEN, 32, width of PC and instruction paths.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk_i  input  1  core clock; all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- stall_i  input  1  hazard unit: hold ID contents this cycle.
- flush_i  input  1  branch taken / mispredict: discard ID and skid contents.
- valid_i  input  1  fetch presents a valid instruction this cycle.
- pc_i  input  XLEN  PC of fetched instruction.
- instr_i  input  XLEN  fetched instruction word.
- fetch_ready_o  output  1  fetch may present a new instruction (skid not full).
- valid_o  output  1  ID stage holds a real instruction.
- pc_o  output  XLEN  PC of ID instruction.
- instr_o  output  XLEN  ID instruction; NOP_INSTR whenever valid_o=0.

Behaviour:
- Reset (async, immediate):
  - valid_o=0, pc_o=0, instr_o=NOP_INSTR.
  - Skid empty; fetch_ready_o=1.
- Fetch acceptance: an instruction is accepted in a cycle iff valid_i && fetch_ready_o. Fetch must hold its input while fetch_ready_o=0.
- Skid states:
  - EMPTY: fetch_ready_o=1.
  - FULL: fetch_ready_o=0.
  - fetch_ready_o is registered (derived from skid state only), with no combinational path from stall_i.
- Priority per cycle: flush_i > stall_i > normal advance.
- flush_i=1:
  - Next cycle: valid_o=0, instr_o=NOP_INSTR, pc_o unchanged.
  - Skid -> EMPTY.
  - The accepted input this cycle (if any) is dropped.
  - flush_i overrides a simultaneous stall_i.
- stall_i=1, flush_i=0:
  - ID register holds all outputs.
  - If skid EMPTY and an instruction is accepted: capture it into skid; skid -> FULL.
  - If skid FULL: nothing is accepted.
- stall_i=0, flush_i=0, skid FULL:
  - ID loads the skid entry (valid_o=1); skid -> EMPTY.
  - The fetch input is not accepted this cycle, since fetch_ready_o was 0.
- stall_i=0, flush_i=0, skid EMPTY:
  - ID loads the accepted input: valid_o=valid_i, pc_o=pc_i.
  - instr_o=instr_i if valid_i, else NOP_INSTR.
- Latency:
  - Fetch-to-ID is 1 cycle when not stalled.
  - A skidded instruction reaches ID on the first unstalled cycle.
- Ordering is strictly preserved: the skid entry is always older than any later fetch.
- Stall for N cycles costs no refetch; fetch is back-pressured after at most one extra instruction.
- Reset mid-stall with skid FULL: the entry is discarded and fetch_ready_o=1 immediately.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt_o [31:0] and flush_cnt_o [31:0].
  - Free-running counters of cycles with stall_i=1 && flush_i=0, and of cycles with flush_i=1.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0 on rst_i.
- Undefined: ports and counters are absent; the other ports behave identically.

Decomposition:
- const.v holds:
  - `INSTR_NOP (32'h0000_0013).
  - Skid state encodings `SKID_EMPTY=1'b0 and `SKID_FULL=1'b1.
  - Existing opcode constants.
- Sub-module if_id_skid_buf contains:
  - Single-entry PC+instr holding register and full flag.
  - Inputs: push, pop, clear.
  - Outputs: full, data.

Test Plan:
- Reset then stream: valid_i=1, pc_i=0x0,0x4,0x8 over 3 cycles -> pc_o=0x0,0x4,0x8 one cycle later each; valid_o=1; fetch_ready_o stays 1.
- Stall 3 cycles while fetch offers pc=0x10 then holds pc=0x14:
  - pc=0x10 is skidded; fetch_ready_o=0 from the next cycle; ID output is held.
  - After release: ID=0x10, then fetch_ready_o=1, then ID=0x14.
- flush_i=1 with stall_i=1 and skid FULL -> next cycle valid_o=0, instr_o=0x0000_0013, fetch_ready_o=1; the skid entry never appears in ID.
- valid_i=0 unstalled -> valid_o=0, instr_o=NOP_INSTR; then valid_i=1, instr_i=0xFFF00093 -> instr_o=0xFFF00093 next cycle.
- Assert rst_i asynchronously mid-cycle with skid FULL -> outputs reach reset values before the next clock edge; fetch_ready_o=1.
- With IF_ID_PERF_EN: 5 stall cycles and 2 flush cycles (one overlapping a stall) -> stall_cnt_o=5 only if none overlap; with the overlap counted as flush, expect stall_cnt_o=4, flush_cnt_o=2.
